mac_tx_framer: RTL and testbench

//  Upstream of pcs_40g_tx: turns a valid/ready frame stream into the per-block MAC/PCS controls.

---
 rtl/mac_tx_framer_pkg.sv | 21 ++
 rtl/mac_tx_framer.sv | 149 ++++++++++++++
 tb/tb_mac_tx_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_framer_pkg.sv
// Shared types and constants for the MAC TX framer: FSM state encoding,
// the preamble/start block pattern and the byte-mask helpers.
package mac_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    TERM = 3'd2,
    IPG  = 3'd3,
    DROP = 3'd4
  } mac_tx_state_e;

  localparam logic [63:0] START_BLK = 64'hD555_5555_5555_55FB;
  localparam logic [7:0]  KEEP_FULL = 8'hFF;

  // True for a non-empty mask whose set bits run contiguously from byte 0.
  function automatic logic keep_contig(input logic [7:0] keep);
    return (keep != 8'h00) && ((keep & (keep + 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/mac_tx_framer.sv
// Frame-stream to per-block PCS control framer (start/data/term/idle/error).
// Optional macro MAC_TX_ERR_EN turns s_err_i beats into error blocks.
module mac_tx_framer
  import mac_tx_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int IPG_BLK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic              s_last_i,
  input  logic              s_err_i,
  output logic              s_ready_o,
  input  logic              ready_i,
  output logic              ctrl_v_o,
  output logic              idle_v_o,
  output logic              start_v_o,
  output logic              term_v_o,
  output logic              err_v_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output mac_tx_state_e     dbg_state_o
);

  localparam int CW = $clog2(IPG_BLK + 1);

  mac_tx_state_e     r_state;
  logic [CW-1:0]     r_ipg_cnt;
  logic              r_ctrl;
  logic              r_idle;
  logic              r_start;
  logic              r_term;
  logic              r_err;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;

  logic w_src_err;
  logic w_keep_full;
  logic w_keep_bad;

`ifdef MAC_TX_ERR_EN
  assign w_src_err = s_err_i;
`else
  logic w_unused_err;
  assign w_src_err    = 1'b0;
  assign w_unused_err = s_err_i;
`endif

  assign w_keep_full = (s_keep_i == KEEP_FULL);
  // Last beat needs a low-first contiguous mask; every other beat must be full.
  assign w_keep_bad  = s_last_i ? !keep_contig(s_keep_i) : !w_keep_full;

  // Handshake: a source beat transfers on a cycle where s_valid_i & s_ready_o.
  // s_ready_o depends only on ready_i and state, never on s_valid_i; when
  // ready_i is low nothing transfers and every register holds.
  assign s_ready_o = ready_i && (r_state == DATA || r_state == DROP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ipg_cnt <= '0;
      r_ctrl    <= 1'b1;
      r_idle    <= 1'b1;
      r_start   <= 1'b0;
      r_term    <= 1'b0;
      r_err     <= 1'b0;
      r_data    <= '0;
      r_keep    <= '0;
    end else if (ready_i) begin
      // Idle block unless a state below overrides it.
      r_ctrl  <= 1'b1;
      r_idle  <= 1'b1;
      r_start <= 1'b0;
      r_term  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      case (r_state)
        IDLE: begin
          if (s_valid_i) begin
            r_idle  <= 1'b0;
            r_start <= 1'b1;
            r_data  <= START_BLK;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (!s_valid_i || w_src_err || w_keep_bad) begin
            r_idle <= 1'b0;
            r_err  <= 1'b1;
            if (s_valid_i && s_last_i) begin
              r_state   <= IPG;
              r_ipg_cnt <= CW'(IPG_BLK);
            end else begin
              r_state <= DROP;
            end
          end else if (!s_last_i || w_keep_full) begin
            r_ctrl <= 1'b0;
            r_idle <= 1'b0;
            r_data <= s_data_i;
            if (s_last_i) r_state <= TERM;
          end else begin
            r_idle    <= 1'b0;
            r_term    <= 1'b1;
            r_data    <= s_data_i;
            r_keep    <= s_keep_i;
            r_state   <= IPG;
            r_ipg_cnt <= CW'(IPG_BLK);
          end
        end
        TERM: begin
          r_idle    <= 1'b0;
          r_term    <= 1'b1;
          r_state   <= IPG;
          r_ipg_cnt <= CW'(IPG_BLK);
        end
        IPG: begin
          if (r_ipg_cnt <= CW'(1)) begin
            r_ipg_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_ipg_cnt <= r_ipg_cnt - CW'(1);
          end
        end
        DROP: begin
          if (s_valid_i && s_last_i) begin
            r_state   <= IPG;
            r_ipg_cnt <= CW'(IPG_BLK);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ctrl_v_o    = r_ctrl;
  assign idle_v_o    = r_idle;
  assign start_v_o   = r_start;
  assign term_v_o    = r_term;
  assign err_v_o     = r_err;
  assign data_o      = r_data;
  assign keep_o      = r_keep;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: directed sequences plus random frames checked
// against a frame-level model of the expected block stream.
module tb_mac_tx_framer;
  import mac_tx_pkg::*;

  localparam int IPG_BLK = 1;
`ifdef MAC_TX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // {ctrl, idle, start, term, err, keep[7:0], data[63:0]}
  typedef logic [76:0] blk_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid_i = 1'b0;
  logic [63:0]   s_data_i = '0;
  logic [7:0]    s_keep_i = '0;
  logic          s_last_i = 1'b0;
  logic          s_err_i = 1'b0;
  logic          s_ready_o;
  logic          ready_i = 1'b1;
  logic          ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o;
  logic [63:0]   data_o;
  logic [7:0]    keep_o;
  mac_tx_state_e dbg_state_o;

  always #5 clk = ~clk;

  mac_tx_framer #(.DATA_W(64), .KEEP_W(8), .IPG_BLK(IPG_BLK)) dut (
    .clk(clk), .reset(reset),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_keep_i(s_keep_i),
    .s_last_i(s_last_i), .s_err_i(s_err_i), .s_ready_o(s_ready_o),
    .ready_i(ready_i),
    .ctrl_v_o(ctrl_v_o), .idle_v_o(idle_v_o), .start_v_o(start_v_o),
    .term_v_o(term_v_o), .err_v_o(err_v_o), .data_o(data_o), .keep_o(keep_o),
    .dbg_state_o(dbg_state_o)
  );

  int   total = 0;
  int   bad = 0;
  blk_t exp_q[$];
  blk_t log_q[$];
  blk_t log_a[$];
  blk_t exp_dir[$];
  logic [63:0] src_d[16];
  logic [7:0]  src_k[16];
  logic adv = 1'b0;
  int   idle_run = 1000;

  function automatic blk_t mk(input logic c, input logic i, input logic s, input logic t,
                              input logic e, input logic [7:0] k, input logic [63:0] d);
    return {c, i, s, t, e, k, d};
  endfunction
  function automatic blk_t b_idle();  return mk(1, 1, 0, 0, 0, 8'h00, 64'h0); endfunction
  function automatic blk_t b_start(); return mk(1, 0, 1, 0, 0, 8'h00, START_BLK); endfunction
  function automatic blk_t b_err();   return mk(1, 0, 0, 0, 1, 8'h00, 64'h0); endfunction
  function automatic blk_t b_data(input logic [63:0] d); return mk(0, 0, 0, 0, 0, 8'h00, d); endfunction
  function automatic blk_t b_term(input logic [7:0] k, input logic [63:0] d);
    return mk(1, 0, 0, 1, 0, k, d);
  endfunction
  function automatic blk_t cur_blk();
    return {ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, keep_o, data_o};
  endfunction

  // Mask is valid for a last beat when it is 1..8 bytes packed from byte 0.
  function automatic bit model_contig(input logic [7:0] k);
    int p;
    logic [7:0] full;
    p = $countones(k);
    full = 8'hFF;
    return (p > 0) && (k == (full >> (8 - p)));
  endfunction

  task automatic check(input string tag, input blk_t got, input blk_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Block monitor: a new block is presented after each edge where ready_i was high.
  always @(posedge clk) adv <= ready_i & ~reset;

  always @(negedge clk) begin
    blk_t b;
    blk_t e;
    int nf;
    if (adv) begin
      b = cur_blk();
      nf = int'(idle_v_o) + int'(start_v_o) + int'(term_v_o) + int'(err_v_o);
      check("flags_onehot", blk_t'((nf <= 1) && (ctrl_v_o == (nf != 0))), blk_t'(1));
      log_q.push_back(b);
      if (start_v_o) check("ipg_gap", blk_t'(idle_run >= IPG_BLK), blk_t'(1));
      if (idle_v_o) idle_run++;
      else begin
        idle_run = 0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("stream", b, e);
      end
    end
  end

  task automatic fill_frame(input int n, input logic [7:0] lkeep, input int bad_idx,
                            input logic [7:0] bad_keep);
    for (int i = 0; i < n; i++) begin
      src_d[i] = {$urandom, $urandom};
      src_k[i] = (i == n - 1) ? lkeep : ((i == bad_idx) ? bad_keep : 8'hFF);
    end
  endtask

  // Expected non-idle blocks of one frame, from the framing rules.
  task automatic model_frame(input int n, input int gap_at, input int err_idx);
    exp_q.push_back(b_start());
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin exp_q.push_back(b_err()); break; end
      if (ERR_EN && i == err_idx) begin exp_q.push_back(b_err()); break; end
      if (i < n - 1) begin
        if (src_k[i] != 8'hFF) begin exp_q.push_back(b_err()); break; end
        exp_q.push_back(b_data(src_d[i]));
      end else if (src_k[i] == 8'hFF) begin
        exp_q.push_back(b_data(src_d[i]));
        exp_q.push_back(b_term(8'h00, 64'h0));
      end else if (model_contig(src_k[i])) begin
        exp_q.push_back(b_term(src_k[i], src_d[i]));
      end else begin
        exp_q.push_back(b_err());
      end
    end
  endtask

  task automatic put_beat(input int i, input int n, input int err_idx);
    s_valid_i = 1'b1;
    s_data_i  = src_d[i];
    s_keep_i  = src_k[i];
    s_last_i  = (i == n - 1);
    s_err_i   = (i == err_idx);
  endtask

  task automatic drive_frame(input int n, input int gap_at, input int err_idx,
                             input int stall_pct, input int stall_at);
    for (int i = 0; i < n; i++) begin
      bit   acc;
      int   cyc;
      blk_t snap;
      if (i == gap_at) begin
        @(negedge clk);
        s_valid_i = 1'b0; s_last_i = 1'b0; s_err_i = 1'b0; ready_i = 1'b1;
      end
      if (i == stall_at) begin
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          put_beat(i, n, err_idx);
          ready_i = 1'b0;
          #1;
          check("stall_ready", blk_t'(s_ready_o), blk_t'(0));
          if (s == 0) snap = cur_blk();
          else check("stall_hold", cur_blk(), snap);
        end
      end
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 64) begin
        @(negedge clk);
        put_beat(i, n, err_idx);
        ready_i = ($urandom_range(0, 99) >= stall_pct);
        #1;
        acc = s_ready_o;
        cyc++;
      end
      check("beat_accept", blk_t'(acc), blk_t'(1));
      if (!acc) return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(negedge clk);
      s_valid_i = 1'b0; s_last_i = 1'b0; s_err_i = 1'b0; ready_i = 1'b1;
    end
  endtask

  task automatic sync_log();
    @(posedge clk);
    #1;
  endtask

  // Compare exp_dir against the log starting at the nth start block.
  task automatic check_log(input string tag, input int nth);
    int j;
    int cnt;
    j = -1;
    cnt = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      if (log_q[k][74]) begin
        cnt++;
        if (cnt == nth) begin j = k; break; end
      end
    end
    check({tag, "_start"}, blk_t'(j >= 0), blk_t'(1));
    if (j < 0) return;
    for (int k = 0; k < exp_dir.size(); k++)
      check(tag, (j + k < log_q.size()) ? log_q[j + k] : '1, exp_dir[k]);
  endtask

  initial begin
    int ja;
    int jb;
    int n;
    int gap;
    int eidx;
    int bidx;
    logic [7:0] lk;

    // Reset held three cycles.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle", blk_t'(idle_v_o), blk_t'(1));
    check("rst_ctrl", blk_t'(ctrl_v_o), blk_t'(1));
    check("rst_ready", blk_t'(s_ready_o), blk_t'(0));
    check("rst_data", blk_t'(data_o), blk_t'(0));
    check("rst_flags", blk_t'({start_v_o, term_v_o, err_v_o, keep_o}), blk_t'(0));
    reset = 1'b0;
    idle_cycles(3);

    // Two full beats + partial last, then back-to-back frame with full last.
    fill_frame(3, 8'h0F, -1, 8'h00);
    model_frame(3, -1, -1);
    exp_dir.delete();
    exp_dir.push_back(b_start());
    exp_dir.push_back(b_data(src_d[0]));
    exp_dir.push_back(b_data(src_d[1]));
    exp_dir.push_back(b_term(8'h0F, src_d[2]));
    exp_dir.push_back(b_idle());
    exp_dir.push_back(b_start());
    sync_log();
    log_q.delete();
    drive_frame(3, -1, -1, 0, -1);
    fill_frame(2, 8'hFF, -1, 8'h00);
    model_frame(2, -1, -1);
    drive_frame(2, -1, -1, 0, -1);
    check_log("partial_last", 1);

    exp_dir.delete();
    exp_dir.push_back(b_start());
    exp_dir.push_back(b_data(src_d[0]));
    exp_dir.push_back(b_data(src_d[1]));
    exp_dir.push_back(b_term(8'h00, 64'h0));
    exp_dir.push_back(b_idle());
    exp_dir.push_back(b_start());
    fill_frame(1, 8'h01, -1, 8'h00);
    model_frame(1, -1, -1);
    drive_frame(1, -1, -1, 0, -1);
    check_log("full_last", 2);

    // Same frame with and without a two-cycle PCS stall.
    idle_cycles(3);
    fill_frame(5, 8'h07, -1, 8'h00);
    sync_log();
    log_q.delete();
    model_frame(5, -1, -1);
    drive_frame(5, -1, -1, 0, -1);
    idle_cycles(4);
    sync_log();
    log_a = log_q;
    log_q.delete();
    model_frame(5, -1, -1);
    drive_frame(5, -1, -1, 0, 2);
    idle_cycles(4);
    sync_log();
    ja = -1;
    jb = -1;
    for (int k = log_a.size() - 1; k >= 0; k--) if (log_a[k][74]) ja = k;
    for (int k = log_q.size() - 1; k >= 0; k--) if (log_q[k][74]) jb = k;
    check("stall_found", blk_t'(ja >= 0 && jb >= 0), blk_t'(1));
    if (ja >= 0 && jb >= 0) begin
      check("stall_len", blk_t'(log_q.size() - jb), blk_t'(log_a.size() - ja));
      for (int k = 0; k < 8; k++)
        check("stall_seq", (jb + k < log_q.size()) ? log_q[jb + k] : '1,
              (ja + k < log_a.size()) ? log_a[ja + k] : '0);
    end

    // Underrun after two beats: error block, rest dropped with idle output.
    fill_frame(5, 8'h3F, -1, 8'h00);
    model_frame(5, 2, -1);
    exp_dir.delete();
    exp_dir.push_back(b_start());
    exp_dir.push_back(b_data(src_d[0]));
    exp_dir.push_back(b_data(src_d[1]));
    exp_dir.push_back(b_err());
    repeat (4) exp_dir.push_back(b_idle());
    sync_log();
    log_q.delete();
    drive_frame(5, 2, -1, 0, -1);
    idle_cycles(3);
    sync_log();
    check_log("underrun", 1);

    // Source error flag on beat 2 of 4.
    fill_frame(4, 8'h0F, -1, 8'h00);
    model_frame(4, -1, 1);
    exp_dir.delete();
    exp_dir.push_back(b_start());
    exp_dir.push_back(b_data(src_d[0]));
    if (ERR_EN) begin
      exp_dir.push_back(b_err());
      exp_dir.push_back(b_idle());
      exp_dir.push_back(b_idle());
    end else begin
      exp_dir.push_back(b_data(src_d[1]));
      exp_dir.push_back(b_data(src_d[2]));
      exp_dir.push_back(b_term(8'h0F, src_d[3]));
    end
    sync_log();
    log_q.delete();
    drive_frame(4, -1, 1, 0, -1);
    idle_cycles(3);
    sync_log();
    check_log("src_err", 1);

    // Random frames with keep violations, underruns, error flags and stalls.
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 8);
      case ($urandom_range(0, 3))
        0: lk = 8'hFF;
        1: lk = 8'hFF >> $urandom_range(1, 7);
        2: lk = 8'($urandom_range(0, 255));
        default: lk = 8'h7F >> $urandom_range(0, 6);
      endcase
      bidx = (n > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 2) : -1;
      gap  = (n > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
      eidx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      fill_frame(n, lk, bidx, 8'($urandom_range(0, 254)));
      model_frame(n, gap, eidx);
      drive_frame(n, gap, eidx, 25, -1);
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(6);
    sync_log();
    check("exp_drained", blk_t'(exp_q.size()), blk_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
